// File: rtl/aud_pkg.sv
// Definitions shared by the audio record, DSP and playback stages.
package aud_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned AddrWDefault = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SHIFT,
    S_WRITE,
    S_PAUSE
  } aud_state_e;

endpackage

// File: rtl/i2s_rx_shift.sv
// I2S receive front end: left-frame-start detection, delay-slot skip and an
// MSB-first word shifter that flags the cycle carrying the last bit of a word.
module i2s_rx_shift
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_adc_dat,
  input  logic              i_align,
  input  logic              i_shift,
  output logic              o_frame_go,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic              lrc_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-2:0] shift_q;
  logic              frame_start;

  assign frame_start = lrc_q & ~i_lrc;

  // The frame-start cycle holds the previous word's LSB, so shifting only
  // begins on the edge after it.
  assign o_frame_go   = i_align & frame_start;
  assign o_word_valid = i_shift && (bit_cnt_q == CntW'(DATA_W - 1));
  assign o_word       = {shift_q, i_adc_dat};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q     <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      lrc_q <= i_lrc;
      if (i_shift) begin
        bit_cnt_q <= bit_cnt_q + CntW'(1);
        shift_q   <= o_word[DATA_W-2:0];
      end else begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// Left-channel I2S recorder: captures one word per frame into SRAM with
// start/pause/stop control and a take length counter.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_adc_dat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W:0]   o_len,
  output logic              o_done,
  output logic              o_recording
);

  localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};

  aud_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              full_q;
  logic              at_max;
  logic              take_clr;
  logic              addr_inc;
  logic              in_align;
  logic              in_shift;
  logic              frame_go;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  assign in_align = (state_q == S_ALIGN);
  assign in_shift = (state_q == S_SHIFT);
  assign at_max   = (addr_q == AddrMax);
  assign take_clr = (state_q == S_IDLE) && i_start;
  assign addr_inc = (state_q == S_WRITE) && !at_max;
  assign addr_d   = take_clr ? '0 : (addr_inc ? addr_q + ADDR_W'(1) : addr_q);

  // A write to the last address saturates the count one past addr_q.
  assign o_len = full_q ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, addr_q};

  i2s_rx_shift #(
    .DATA_W(DATA_W)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_lrc       (i_lrc),
    .i_adc_dat   (i_adc_dat),
    .i_align     (in_align),
    .i_shift     (in_shift),
    .o_frame_go  (frame_go),
    .o_word_valid(word_valid),
    .o_word      (word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;
      full_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (take_clr) begin
        full_q <= 1'b0;
      end else if ((state_q == S_WRITE) && at_max) begin
        full_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      o_we        <= 1'b0;
      o_done      <= 1'b0;
      o_recording <= 1'b0;
      o_data      <= '0;
      o_address   <= '0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q     <= S_ALIGN;
            o_recording <= 1'b1;
          end
        end
        S_ALIGN: begin
          if (i_stop) begin
            state_q     <= S_IDLE;
            o_done      <= 1'b1;
            o_recording <= 1'b0;
          end else if (i_pause) begin
            state_q     <= S_PAUSE;
            o_recording <= 1'b0;
          end else if (frame_go) begin
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_stop) begin
            state_q     <= S_IDLE;
            o_done      <= 1'b1;
            o_recording <= 1'b0;
          end else if (i_pause) begin
            state_q     <= S_PAUSE;
            o_recording <= 1'b0;
          end else if (word_valid) begin
            state_q   <= S_WRITE;
            o_we      <= 1'b1;
            o_data    <= word;
            o_address <= addr_q;
          end
        end
        S_WRITE: begin
          // The write in flight always completes; controls only pick the exit.
          if (at_max || i_stop) begin
            state_q     <= S_IDLE;
            o_done      <= 1'b1;
            o_recording <= 1'b0;
          end else if (i_pause) begin
            state_q     <= S_PAUSE;
            o_recording <= 1'b0;
          end else begin
            state_q <= S_ALIGN;
          end
        end
        S_PAUSE: begin
          if (i_stop) begin
            state_q <= S_IDLE;
            o_done  <= 1'b1;
          end else if (i_start && !i_pause) begin
            state_q     <= S_ALIGN;
            o_recording <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          o_recording <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 The module SHALL have parameter DATA_W, 16, sample width in bits.
REQ-002 The module SHALL have parameter ADDR_W, 20, SRAM word-address width.
REQ-003 The module SHALL have port i_clk  in  1  clock; this is the codec bit clock (BCLK), and all logic samples on its rising edge.
REQ-004 The module SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port i_lrc  in  1  ADC left/right clock; 0 = left channel.
REQ-006 The module SHALL have port i_adc_dat  in  1  serial ADC data, I2S format, MSB first.
REQ-007 The module SHALL have ports i_start, i_pause, i_stop  in  1 each  level-sampled control requests.
REQ-008 The module SHALL have port o_address  out  ADDR_W  SRAM write address.
REQ-009 The module SHALL have port o_data  out  DATA_W  SRAM write data.
REQ-010 The module SHALL have port o_we  out  1  one-cycle SRAM write strobe.
REQ-011 The module SHALL have port o_len  out  ADDR_W+1  count of words written in the current or last take.
REQ-012 The module SHALL have port o_done  out  1  one-cycle pulse when a take ends.
REQ-013 The module SHALL have port o_recording  out  1  high in S_ALIGN, S_SHIFT and S_WRITE.

Function
REQ-014 The FSM SHALL have the states S_IDLE, S_ALIGN, S_SHIFT, S_WRITE and S_PAUSE.
REQ-015 Left-frame start SHALL be detected in the cycle where the registered previous i_lrc is 1 and the current i_lrc is 0.
REQ-016 In S_IDLE, i_start SHALL cause a transition to S_ALIGN and clear the address and o_len to 0; i_pause and i_stop SHALL be ignored in S_IDLE.
REQ-017 In S_ALIGN, a left-frame start SHALL cause a transition to S_SHIFT with the bit counter at 0; this cycle is the I2S 1-bit delay slot, and the bit in it SHALL be discarded.
REQ-018 In S_SHIFT, i_adc_dat SHALL be shifted in MSB-first on each of exactly DATA_W consecutive cycles; after the DATA_W-th bit the FSM SHALL go to S_WRITE.
REQ-019 In S_WRITE, o_we SHALL be 1 for exactly one cycle with o_data = assembled word and o_address = current address; the address and o_len SHALL increment by 1 on exit.
REQ-020 After S_WRITE the FSM SHALL return to S_ALIGN; only the left channel SHALL be captured, so the right half-frame is skipped.
REQ-021 o_we SHALL be 0 in every state other than S_WRITE.
REQ-022 o_data and o_address SHALL hold their values between writes.
REQ-023 A write SHALL occur DATA_W+1 cycles after the left-frame-start cycle; the frame-start cycle is cycle 0 and the o_we cycle is cycle DATA_W+1.
REQ-024 i_pause in S_ALIGN or S_SHIFT SHALL cause a transition to S_PAUSE and discard any partial word; no write SHALL occur.
REQ-025 In S_PAUSE, i_start SHALL cause a transition to S_ALIGN and capture SHALL realign to the next left frame, with the address retained.
REQ-026 i_stop in S_ALIGN, S_SHIFT or S_PAUSE SHALL cause a transition to S_IDLE, drop any partial word, and pulse o_done in the following cycle.
REQ-027 When stop and start or pause are simultaneous, i_stop SHALL win; i_pause SHALL beat i_start.
REQ-028 i_stop or i_pause asserted during S_WRITE SHALL NOT cancel the write: the write completes and is counted, and the FSM then goes to S_IDLE (with o_done) or S_PAUSE respectively.
REQ-029 A write to address 2^ADDR_W-1 SHALL end the take: the FSM goes to S_IDLE, o_len = 2^ADDR_W, and o_done pulses; the address SHALL NOT wrap.
REQ-030 o_len SHALL remain stable in S_IDLE until the next i_start.

Reset
REQ-031 On i_rst_n low, the FSM SHALL go to S_IDLE asynchronously.
REQ-032 On reset, o_address, o_data, o_len, the bit counter, the shift register and the previous-i_lrc register SHALL clear to 0.
REQ-033 On reset, o_we, o_done and o_recording SHALL clear to 0.
REQ-034 Reset asserted mid-word SHALL abort the capture with no write.
REQ-035 The first frame-start detection after reset SHALL require a 1-to-0 transition of i_lrc observed after reset release.

Structure
REQ-036 The state enum, DATA_W and ADDR_W defaults SHALL live in the shared package aud_pkg, which is also used by the DSP and player stages.
REQ-037 A single sub-module i2s_rx_shift SHALL implement the frame-start edge detector, the delay-slot skip, the DATA_W-bit shifter and a word-valid pulse; aud_recorder SHALL own the FSM, address counter and controls.

Verification
REQ-038 The bench SHALL cover: start, then 3 left frames carrying 16'h8001, 16'h7FFE and 16'h1234 -> o_we pulses at addresses 0, 1 and 2 with those data, o_len = 3, and right-channel data never written.
REQ-039 The bench SHALL cover: start with i_lrc already 0 -> no write until the next 1-to-0 transition; o_we is asserted exactly 17 cycles after the frame-start cycle.
REQ-040 The bench SHALL cover: pause on bit 8 of a word -> no write; resume at the next start -> the next complete frame is written at the next address, with no gap.
REQ-041 The bench SHALL cover: i_stop raised in the S_WRITE cycle of word 5 -> the word is written at address 4, o_len = 5, and o_done pulses once.
REQ-042 The bench SHALL cover: preload the address to 20'hFFFFE, then run 3 frames -> 2 writes, o_done, S_IDLE, o_len = 21'h100000, and no third write.
REQ-043 The bench SHALL cover: async reset mid-S_SHIFT -> all outputs are 0 immediately and stay 0 until the next start.
